// File: rtl/vec_dot_engine.sv
// Dot-product engine: 2*VEC_LEN word store (A then B) with a sequential multiply-accumulate run.
// Build option: define VEC_DOT_SIGNED_EN for two's-complement elements/result; unsigned otherwise.
module vec_dot_engine #(
  parameter int unsigned WORD_W  = 4,
  parameter int unsigned VEC_LEN = 16,
  localparam int unsigned MEM_D  = 2 * VEC_LEN,
  localparam int unsigned MEM_AW = $clog2(MEM_D),
  localparam int unsigned ADDR_W = MEM_AW + 1,
  localparam int unsigned ACC_W  = 2 * WORD_W + $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o,
  output logic [ACC_W-1:0]  result_o,
  output logic [1:0]        state_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RUN   = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  state_t              state;
  op_t                 op;
  logic [WORD_W-1:0]   mem [MEM_D];
  logic [ACC_W-1:0]    acc;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   n_len;

  logic                addr_ok;
  logic                wr_en;
  logic [ADDR_W-1:0]   n_clamp;
  logic [WORD_W-1:0]   a_word;
  logic [WORD_W-1:0]   b_word;
  logic [ACC_W-1:0]    a_ext;
  logic [ACC_W-1:0]    b_ext;
  logic [ACC_W-1:0]    prod;
  logic [ACC_W-1:0]    acc_sum;
  logic                last;

  assign op      = op_t'(op_i);
  assign addr_ok = addr_i < ADDR_W'(MEM_D);
  assign wr_en   = (op == OP_WRITE) && addr_ok && (state != S_RUN);
  assign n_clamp = (addr_i > ADDR_W'(VEC_LEN)) ? ADDR_W'(VEC_LEN) : addr_i;
  assign a_word  = mem[MEM_AW'(idx)];
  assign b_word  = mem[MEM_AW'(idx) + MEM_AW'(VEC_LEN)];

  // Operands widened to the accumulator width so the product cannot overflow.
`ifdef VEC_DOT_SIGNED_EN
  assign a_ext = {{(ACC_W-WORD_W){a_word[WORD_W-1]}}, a_word};
  assign b_ext = {{(ACC_W-WORD_W){b_word[WORD_W-1]}}, b_word};
`else
  assign a_ext = {{(ACC_W-WORD_W){1'b0}}, a_word};
  assign b_ext = {{(ACC_W-WORD_W){1'b0}}, b_word};
`endif

  assign prod    = a_ext * b_ext;
  assign acc_sum = acc + prod;
  assign last    = (idx + ADDR_W'(1)) == n_len;

  assign state_o = state;

  // Vector storage carries no reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[MEM_AW'(addr_i)] <= wdata_i;
    end
  end

  // Control FSM with registered read data, result and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rdata_o  <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
      acc      <= '0;
      idx      <= '0;
      n_len    <= '0;
    end else begin
      done_o <= 1'b0;

      if (op == OP_READ) begin
        rdata_o <= addr_ok ? mem[MEM_AW'(addr_i)] : '0;
      end

      case (state)
        S_IDLE: begin
          if (op == OP_CLEAR) begin
            result_o <= '0;
            acc      <= '0;
            idx      <= '0;
          end else if (op == OP_RUN) begin
            n_len <= n_clamp;
            acc   <= '0;
            idx   <= '0;
            if (n_clamp == '0) begin
              state    <= S_DONE;
              result_o <= '0;
              done_o   <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          if (op == OP_CLEAR) begin
            state    <= S_IDLE;
            result_o <= '0;
            acc      <= '0;
            idx      <= '0;
          end else begin
            acc <= acc_sum;
            idx <= idx + ADDR_W'(1);
            if (last) begin
              state    <= S_DONE;
              result_o <= acc_sum;
              done_o   <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (op == OP_CLEAR) begin
            state    <= S_IDLE;
            result_o <= '0;
            acc      <= '0;
            idx      <= '0;
          end else if (op != OP_RUN) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_dot_engine.sv
// Scoreboard bench for vec_dot_engine: stimulus queues expected reads/results, a monitor pops and compares.
module tb_vec_dot_engine;

  localparam logic [1:0] READ  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  logic        clk;
  logic        rst;
  logic [1:0]  op_i;
  logic [5:0]  addr_i;
  logic [3:0]  wdata_i;
  logic [3:0]  rdata_o;
  logic [11:0] result_o;
  logic [1:0]  state_o;
  logic        done_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  logic rd_pend = 1'b0;

  logic [3:0]  mdl [32];
  logic [3:0]  rd_q[$];
  logic [11:0] res_q[$];

  vec_dot_engine dut (
    .clk(clk), .rst(rst), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .result_o(result_o), .state_o(state_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
  endtask

  // Monitor: rdata one cycle after a sampled READ, result whenever done_o pulses.
  always @(posedge clk) rd_pend <= (op_i == READ) && !rst;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) check("rdata_unexpected", 32'(rdata_o), 32'hDEAD);
      else check("rdata", 32'(rdata_o), 32'(rd_q.pop_front()));
    end
    if (done_o) begin
      done_cnt++;
      if (res_q.size() == 0) check("done_unexpected", 32'(result_o), 32'hBEEF);
      else check("result", 32'(result_o), 32'(res_q.pop_front()));
    end
  end

  task automatic step(input logic [1:0] op, input logic [5:0] addr, input logic [3:0] wd);
    op_i = op; addr_i = addr; wdata_i = wd;
    if (op == READ) rd_q.push_back((addr < 6'd32) ? mdl[addr] : 4'd0);
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [3:0] d);
    step(WRITE, 6'(a), d);
    if (a < 32) mdl[a] = d;
  endtask

  task automatic run_and_wait(input string nm, input logic [5:0] n, input logic [11:0] exp,
                              input int exp_cyc);
    int cyc;
    int d0;
    d0 = done_cnt;
    res_q.push_back(exp);
    step(RUN, n, 4'd0);
    cyc = 0;
    while (state_o == 2'd1 && cyc < 40) begin
      step(RUN, 6'd0, 4'd0);
      cyc++;
    end
    @(negedge clk); #1;
    check({nm, "_run_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({nm, "_state_done"}, 32'(state_o), 32'd2);
    check({nm, "_result"}, 32'(result_o), 32'(exp));
    check({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst = 1'b1; op_i = READ; addr_i = '0; wdata_i = '0;
    #1;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_result", 32'(result_o), 32'd0);
    check("reset_rdata", 32'(rdata_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // A=1, B=2 -> 32 over 16 cycles
    for (int i = 0; i < 16; i++) begin wr(i, 4'd1); wr(16 + i, 4'd2); end
    step(READ, 6'd3, 4'd0);
    step(READ, 6'd20, 4'd0);
    step(READ, 6'd40, 4'd0);
    run_and_wait("ones_twos", 6'd16, 12'd32, 16);

    // All 0xF: unsigned 3600, signed (-1*-1)*16 = 16; then clamp n=20
    for (int i = 0; i < 32; i++) wr(i, 4'hF);
`ifdef VEC_DOT_SIGNED_EN
    run_and_wait("all_f", 6'd16, 12'd16, 16);
`else
    run_and_wait("all_f", 6'd16, 12'd3600, 16);
`endif
    step(READ, 6'd31, 4'd0);
    check("done_read_to_idle", 32'(state_o), 32'd0);
`ifdef VEC_DOT_SIGNED_EN
    check("result_held", 32'(result_o), 32'd16);
    run_and_wait("clamp20", 6'd20, 12'd16, 16);
`else
    check("result_held", 32'(result_o), 32'd3600);
    run_and_wait("clamp20", 6'd20, 12'd3600, 16);
`endif

    // A=8, B=7: unsigned 896 (0x380), signed -896 (0xC80); A=B=8 -> 1024 either way
    for (int i = 0; i < 16; i++) begin wr(i, 4'h8); wr(16 + i, 4'h7); end
`ifdef VEC_DOT_SIGNED_EN
    run_and_wait("a8_b7", 6'd16, 12'hC80, 16);
`else
    run_and_wait("a8_b7", 6'd16, 12'h380, 16);
`endif
    for (int i = 0; i < 16; i++) wr(16 + i, 4'h8);
    run_and_wait("a8_b8", 6'd16, 12'h400, 16);

    // n=3 with a WRITE during RUNNING: write dropped, result 3*64 = 192
    step(READ, 6'd0, 4'd0);
    d0 = done_cnt;
    res_q.push_back(12'd192);
    step(RUN, 6'd3, 4'd0);
    check("n3_running", 32'(state_o), 32'd1);
    step(WRITE, 6'd0, 4'd5);
    step(RUN, 6'd0, 4'd0);
    step(RUN, 6'd0, 4'd0);
    @(negedge clk); #1;
    check("n3_done_state", 32'(state_o), 32'd2);
    check("n3_result", 32'(result_o), 32'd192);
    check("n3_done_pulses", 32'(done_cnt - d0), 32'd1);
    step(READ, 6'd0, 4'd0);
    step(READ, 6'd16, 4'd0);
    check("n3_result_held", 32'(result_o), 32'd192);

    // CLEAR mid-run: back to IDLE, result zeroed, no done pulse
    d0 = done_cnt;
    step(RUN, 6'd16, 4'd0);
    for (int i = 0; i < 4; i++) step(RUN, 6'd0, 4'd0);
    step(CLEAR, 6'd0, 4'd0);
    check("clear_state", 32'(state_o), 32'd0);
    check("clear_result", 32'(result_o), 32'd0);
    repeat (3) step(READ, 6'd5, 4'd0);
    check("clear_no_done", 32'(done_cnt - d0), 32'd0);

    // Nonzero result, then asynchronous reset mid-run
    run_and_wait("n1", 6'd1, 12'd64, 1);
    step(WRITE, 6'd63, 4'd1);
    check("done_write_to_idle", 32'(state_o), 32'd0);
    d0 = done_cnt;
    step(RUN, 6'd16, 4'd0);
    for (int i = 0; i < 4; i++) step(RUN, 6'd0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_result", 32'(result_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) step(CLEAR, 6'd0, 4'd0);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_state_idle", 32'(state_o), 32'd0);
    step(READ, 6'd7, 4'd0);

    // n=0: DONE on the RUN edge, RUN holds DONE without retrigger, READ returns to IDLE
    run_and_wait("n0", 6'd0, 12'd0, 0);
    d0 = done_cnt;
    repeat (3) step(RUN, 6'd5, 4'd0);
    check("n0_hold_state", 32'(state_o), 32'd2);
    check("n0_no_retrigger", 32'(done_cnt - d0), 32'd0);
    step(READ, 6'd1, 4'd0);
    check("n0_read_idle", 32'(state_o), 32'd0);
    check("n0_result_held", 32'(result_o), 32'd0);

    step(CLEAR, 6'd0, 4'd0);
    @(negedge clk); #1;
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    check("res_queue_drained", 32'(res_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vec_dot_engine.md
VEC_DOT_ENGINE -- requirements
Module: vec_dot_engine

Interface
REQ-001 Parameter WORD_W, default 4, SHALL be the bit width of one vector element.
REQ-002 Parameter VEC_LEN, default 16, SHALL be the number of elements per vector; it SHALL be a power of two, at least 2.
REQ-003 Derived ADDR_W = clog2(2*VEC_LEN)+1 and ACC_W = 2*WORD_W + clog2(VEC_LEN), giving 6 and 12 at the defaults.
REQ-004 clk  input  1  Single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  Reset, asynchronous and active-high.
REQ-006 op_i  input  2  Command: 0 READ, 1 WRITE, 2 RUN, 3 CLEAR; sampled every cycle.
REQ-007 addr_i  input  ADDR_W  Element address for READ/WRITE; run length for RUN.
REQ-008 wdata_i  input  WORD_W  Write data.
REQ-009 rdata_o  output  WORD_W  Registered read data.
REQ-010 result_o  output  ACC_W  Registered dot-product result.
REQ-011 state_o  output  2  FSM state: 0 IDLE, 1 RUNNING, 2 DONE.
REQ-012 done_o  output  1  One-cycle pulse on the edge that enters DONE.

Function
REQ-013 Storage SHALL be 2*VEC_LEN words: addresses 0..VEC_LEN-1 hold vector A and VEC_LEN..2*VEC_LEN-1 hold vector B.
REQ-014 WRITE SHALL store wdata_i at addr_i on the same edge. WRITE to an address >= 2*VEC_LEN SHALL be ignored.
REQ-015 READ SHALL load rdata_o with mem[addr_i] on the next edge (1-cycle latency). An address >= 2*VEC_LEN SHALL return 0. rdata_o holds its value when op_i is not READ.
REQ-016 IDLE + RUN SHALL latch n = addr_i, clamped to VEC_LEN, clear the accumulator and index, and go to RUNNING.
REQ-017 RUN with n = 0 SHALL go to DONE on the next edge, with result_o = 0 and done_o pulsed.
REQ-018 RUNNING SHALL add A[idx]*B[idx] to the accumulator once per cycle and increment idx.
  - After the n-th product, the FSM SHALL go to DONE and load result_o with the final sum.
  - The result SHALL be visible exactly n cycles after the RUN edge.
REQ-019 Products and sums SHALL be computed at full ACC_W width with no overflow or truncation.
REQ-020 In RUNNING, WRITE SHALL be ignored (memory protected), READ SHALL operate normally, and RUN SHALL have no effect.
REQ-021 CLEAR in any state SHALL abort any run, zero result_o, and go to IDLE on the next edge.
REQ-022 In DONE, RUN SHALL keep the state at DONE with no retrigger. READ or WRITE SHALL go to IDLE, perform the access, and hold result_o.
REQ-023 result_o SHALL change only on entering DONE, on CLEAR, or on reset.

Reset
REQ-024 rst high SHALL immediately force state_o=IDLE, result_o=0, rdata_o=0, done_o=0, and accumulator/index=0, independent of clk.
REQ-025 Vector memory SHALL NOT be reset; contents are undefined after power-up.
REQ-026 rst asserted mid-run SHALL abandon the run with no result update. After rst deasserts, the first edge SHALL accept commands.

Configuration
REQ-027 Macro VEC_DOT_SIGNED_EN SHALL select the arithmetic:
  - Defined: elements SHALL be two's-complement, sign-extended before multiply; result_o SHALL be two's-complement.
  - Undefined: all elements and result_o SHALL be unsigned.

Verification
REQ-028 Write A[i]=1 and B[i]=2 for all 16 elements, RUN n=16 -> state RUNNING for 16 cycles, then DONE, result_o=32, done_o high one cycle.
REQ-029 Unsigned build, all elements 0xF, RUN n=16 -> result_o=3600 (0xE10). RUN n=20 -> clamped to 16, result 3600.
REQ-030 Signed build, A[i]=0x8 and B[i]=0x7, RUN n=16 -> result_o=0xC80 (-896). A=B=0x8 -> 0x400 (1024).
REQ-031 RUN n=3, WRITE A[0]=5 during RUNNING -> write ignored; READ addr 0 afterwards returns the old value one cycle later.
REQ-032 RUN n=16, CLEAR on cycle 5 -> IDLE next edge, result_o=0, no done_o pulse. Repeat with rst on cycle 5 -> same outcome, asynchronously.
REQ-033 RUN n=0 -> DONE after 1 cycle, result_o=0. Holding RUN in DONE -> stays DONE. READ then -> IDLE with result held.
